traffic_light_sequencer: RTL and testbench

//  Timed phase generator driving the 4-bit one-hot colour bus {left,green,amber,red}

---
 rtl/traffic_light_sequencer.sv | 162 ++++++++++++++++
 tb/tb_traffic_light_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_sequencer.sv
`timescale 1ns/1ps
// Timed RED -> [LEFT] -> GREEN -> AMBER phase generator feeding the light display decoder.
// Colour is registered; define FLASH_AMBER_EN to build the night amber-flash mode.
module traffic_light_sequencer #(
    parameter int RED_TICKS   = 10,
    parameter int LEFT_TICKS  = 4,
    parameter int GREEN_TICKS = 8,
    parameter int AMBER_TICKS = 3,
    parameter int FLASH_TICKS = 2,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       left_req,
    input  logic       flash_mode,
    output logic [3:0] colour,
    output logic       phase_start,
    output logic       left_pending
);

    localparam int MAX_TICKS = (1 << CNT_W) - 1;

    if (RED_TICKS   < 1 || RED_TICKS   > MAX_TICKS ||
        LEFT_TICKS  < 1 || LEFT_TICKS  > MAX_TICKS ||
        GREEN_TICKS < 1 || GREEN_TICKS > MAX_TICKS ||
        AMBER_TICKS < 1 || AMBER_TICKS > MAX_TICKS ||
        FLASH_TICKS < 1 || FLASH_TICKS > MAX_TICKS) begin : g_bad_ticks
        $error("traffic_light_sequencer: every phase tick count must be in 1..2**CNT_W-1");
    end

    typedef enum logic [2:0] {
        S_RED   = 3'd0,
        S_LEFT  = 3'd1,
        S_GREEN = 3'd2,
`ifdef FLASH_AMBER_EN
        S_AMBER = 3'd3,
        S_FLASH = 3'd4
`else
        S_AMBER = 3'd3
`endif
    } state_t;

    localparam logic [3:0] C_RED   = 4'b0001;
    localparam logic [3:0] C_AMBER = 4'b0010;
    localparam logic [3:0] C_GREEN = 4'b0100;
    localparam logic [3:0] C_LEFT  = 4'b1000;

    localparam logic [CNT_W-1:0] RED_LOAD   = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] LEFT_LOAD  = CNT_W'(LEFT_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LOAD = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] AMBER_LOAD = CNT_W'(AMBER_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef FLASH_AMBER_EN
    localparam logic [3:0]       C_OFF      = 4'b0000;
    localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TICKS - 1);
`else
    logic w_unused_flash;
    assign w_unused_flash = flash_mode;
`endif

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_colour;
    logic             r_phase_start;
    logic             r_left_pending;

    logic             w_exit;
    logic             w_want_left;
    state_t           w_next;

    function automatic state_t next_phase(input state_t s, input logic want_left);
        case (s)
            S_RED:   next_phase = want_left ? S_LEFT : S_GREEN;
            S_LEFT:  next_phase = S_GREEN;
            S_GREEN: next_phase = S_AMBER;
            default: next_phase = S_RED;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] load_of(input state_t s);
        case (s)
            S_LEFT:  load_of = LEFT_LOAD;
            S_GREEN: load_of = GREEN_LOAD;
            S_AMBER: load_of = AMBER_LOAD;
            default: load_of = RED_LOAD;
        endcase
    endfunction

    function automatic logic [3:0] colour_of(input state_t s);
        case (s)
            S_LEFT:  colour_of = C_LEFT;
            S_GREEN: colour_of = C_GREEN;
            S_AMBER: colour_of = C_AMBER;
            default: colour_of = C_RED;
        endcase
    endfunction

    // A phase of N ticks ends on the tick that finds the counter already at zero.
    assign w_exit      = tick && (r_cnt == '0);
    assign w_want_left = r_left_pending || left_req;
    assign w_next      = next_phase(r_state, w_want_left);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_RED;
            r_cnt          <= RED_LOAD;
            r_colour       <= C_RED;
            r_phase_start  <= 1'b0;
            r_left_pending <= 1'b0;
        end else begin
            r_phase_start <= 1'b0;
`ifdef FLASH_AMBER_EN
            if (flash_mode && r_state != S_FLASH) begin
                r_state       <= S_FLASH;
                r_cnt         <= FLASH_LOAD;
                r_colour      <= C_AMBER;
                r_phase_start <= 1'b1;
            end else if (r_state == S_FLASH) begin
                // Leaving flash always restarts a full RED; the pending left request is kept.
                if (!flash_mode) begin
                    r_state       <= S_RED;
                    r_cnt         <= RED_LOAD;
                    r_colour      <= C_RED;
                    r_phase_start <= 1'b1;
                end else if (tick) begin
                    if (r_cnt == '0) begin
                        r_cnt    <= FLASH_LOAD;
                        r_colour <= (r_colour == C_AMBER) ? C_OFF : C_AMBER;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
            end else begin
`else
            begin
`endif
                if (w_exit) begin
                    r_state       <= w_next;
                    r_cnt         <= load_of(w_next);
                    r_colour      <= colour_of(w_next);
                    r_phase_start <= 1'b1;
                end else if (tick) begin
                    r_cnt <= r_cnt - CNT_ONE;
                end

                // Entering LEFT consumes the request, even one arriving in the same cycle.
                if (w_exit && w_next == S_LEFT) begin
                    r_left_pending <= 1'b0;
                end else if (left_req && r_state != S_LEFT) begin
                    r_left_pending <= 1'b1;
                end
            end
        end
    end

    assign colour       = r_colour;
    assign phase_start  = r_phase_start;
    assign left_pending = r_left_pending;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
`timescale 1ns/1ps
// Directed bench for traffic_light_sequencer with default parameters (10/4/8/3, flash 2).
module tb_traffic_light_sequencer;

    localparam logic [3:0] OFF   = 4'b0000;
    localparam logic [3:0] RED   = 4'b0001;
    localparam logic [3:0] AMBER = 4'b0010;
    localparam logic [3:0] GREEN = 4'b0100;
    localparam logic [3:0] LEFT  = 4'b1000;

    logic       clk        = 1'b0;
    logic       reset_n    = 1'b0;
    logic       tick       = 1'b0;
    logic       left_req   = 1'b0;
    logic       flash_mode = 1'b0;
    logic [3:0] colour;
    logic       phase_start;
    logic       left_pending;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tick;
        logic       req;
        logic [3:0] col;
        logic       ps;
        logic       lp;
    } vec_t;

    vec_t vecs[17];

    traffic_light_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .left_req     (left_req),
        .flash_mode   (flash_mode),
        .colour       (colour),
        .phase_start  (phase_start),
        .left_pending (left_pending)
    );

    always #5 clk = ~clk;

    task automatic chk_out(input string nm, input logic [3:0] col, input logic ps, input logic lp);
        checks++;
        if (colour !== col || phase_start !== ps || left_pending !== lp) begin
            errors++;
            $display("FAIL %s: actual colour=%b phase_start=%b left_pending=%b, required colour=%b phase_start=%b left_pending=%b",
                     nm, colour, phase_start, left_pending, col, ps, lp);
        end
    endtask

    task automatic step(input logic t);
        @(negedge clk);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    // One full phase with a tick every 4th clock; the final tick's new colour is checked by the caller.
    task automatic phase(input string nm, input logic [3:0] col, input int n, input logic ps0, input logic lp);
        chk_out({nm, " entry"}, col, ps0, lp);
        for (int k = 1; k <= n; k++) begin
            repeat (3) begin
                step(1'b0);
                chk_out({nm, " idle"}, col, 1'b0, lp);
            end
            step(1'b1);
            if (k < n) chk_out({nm, " tick"}, col, 1'b0, lp);
        end
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, RED,   1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, RED,   1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, RED,   1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, RED,   1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, RED,   1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, LEFT,  1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, LEFT,  1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, LEFT,  1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b0, LEFT,  1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b0, LEFT,  1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b0, GREEN, 1'b1, 1'b0};
        vecs[16] = '{1'b1, 1'b0, GREEN, 1'b0, 1'b0};

        #12;
        chk_out("reset values", RED, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Tick every clock: RED with a pulse on its 3rd tick, LEFT served, request in LEFT dropped.
        for (int i = 0; i < 17; i++) begin
            left_req = vecs[i].req;
            step(vecs[i].tick);
            left_req = 1'b0;
            chk_out($sformatf("vec%0d", i), vecs[i].col, vecs[i].ps, vecs[i].lp);
        end

        // Asynchronous reset in the middle of GREEN with a request pending.
        left_req = 1'b1;
        step(1'b0);
        left_req = 1'b0;
        chk_out("green pending", GREEN, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_out("async reset", RED, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        phase("t2 red", RED, 10, 1'b0, 1'b0);
        phase("t2 green", GREEN, 8, 1'b1, 1'b0);
        phase("t2 amber", AMBER, 3, 1'b1, 1'b0);

        // Request arriving in the very clock of the RED exit tick.
        chk_out("t4 red entry", RED, 1'b1, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b1);
            chk_out("t4 red tick", RED, 1'b0, 1'b0);
        end
        left_req = 1'b1;
        step(1'b1);
        left_req = 1'b0;
        chk_out("t4 left entry", LEFT, 1'b1, 1'b0);
        left_req = 1'b1;
        step(1'b0);
        left_req = 1'b0;
        chk_out("t4 left drop", LEFT, 1'b0, 1'b0);
        phase("t4 left", LEFT, 4, 1'b0, 1'b0);
        phase("t4 green", GREEN, 8, 1'b1, 1'b0);
        phase("t4 amber", AMBER, 3, 1'b1, 1'b0);
        phase("t4 red skip", RED, 10, 1'b1, 1'b0);
        phase("t5 green", GREEN, 8, 1'b1, 1'b0);

        // Tick stalled mid-AMBER for 100 clocks; a request raised during the stall is kept.
        chk_out("t5 amber entry", AMBER, 1'b1, 1'b0);
        step(1'b1);
        chk_out("t5 amber tick1", AMBER, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) left_req = 1'b1;
            step(1'b0);
            left_req = 1'b0;
            chk_out("t5 stall", AMBER, 1'b0, (i >= 50));
        end
        step(1'b1);
        chk_out("t5 amber tick2", AMBER, 1'b0, 1'b1);
        step(1'b1);
        chk_out("t5 red entry", RED, 1'b1, 1'b1);
        phase("t3 red pending", RED, 10, 1'b1, 1'b1);
        phase("t3 left served", LEFT, 4, 1'b1, 1'b0);
        chk_out("t3 green entry", GREEN, 1'b1, 1'b0);

`ifdef FLASH_AMBER_EN
        flash_mode = 1'b1;
        step(1'b0);
        chk_out("t6 flash entry", AMBER, 1'b1, 1'b0);
        step(1'b1);
        chk_out("t6 flash amber", AMBER, 1'b0, 1'b0);
        step(1'b1);
        chk_out("t6 flash off", OFF, 1'b0, 1'b0);
        step(1'b1);
        chk_out("t6 flash off2", OFF, 1'b0, 1'b0);
        step(1'b1);
        chk_out("t6 flash amber2", AMBER, 1'b0, 1'b0);
        flash_mode = 1'b0;
        step(1'b0);
        chk_out("t6 flash exit", RED, 1'b1, 1'b0);
        phase("t6 red full", RED, 10, 1'b1, 1'b0);
        chk_out("t6 green", GREEN, 1'b1, 1'b0);
`else
        flash_mode = 1'b1;
        repeat (4) begin
            step(1'b1);
            chk_out("flash ignored", GREEN, 1'b0, 1'b0);
        end
        flash_mode = 1'b0;
        phase("green rest", GREEN, 4, 1'b0, 1'b0);
        chk_out("amber after green", AMBER, 1'b1, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
